// File: rtl/decode_cfg_sequencer_pkg.sv
// Shared definitions for the decode window-table config sequencer:
// FSM state encoding, the boot-ROM end-of-table marker and the layout
// of the window table (four banks of NUM_WIN entries each).
package decode_cfg_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LATCH = 3'd2,
        ST_WRITE = 3'd3,
        ST_HOST  = 3'd4,
        ST_HACK  = 3'd5
    } state_t;

    // A ROM entry whose address byte equals this value terminates the load early.
    localparam logic [7:0] CFG_END_MARK = 8'hFF;

    // Window table: base, mask, slot and op banks, NUM_WIN entries each.
    function automatic int table_size(input int num_win);
        return 4 * num_win;
    endfunction

    function automatic int base_off(input int num_win);
        return 0 * num_win;
    endfunction

    function automatic int mask_off(input int num_win);
        return 1 * num_win;
    endfunction

    function automatic int slot_off(input int num_win);
        return 2 * num_win;
    endfunction

    function automatic int op_off(input int num_win);
        return 3 * num_win;
    endfunction

endpackage

// File: rtl/decode_cfg_sequencer_sync2.sv
// Two-flop synchronizer for a single asynchronous level (CPU /IORQ).
// Reset value is a parameter so the bus reads as idle straight out of reset.
module decode_cfg_sequencer_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic sync_reg;

    // Back-to-back capture flops; only sync_reg is used downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= RST_VAL;
            sync_reg <= RST_VAL;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/decode_cfg_sequencer.sv
// Sequencer owning the address-decode window-table config port.
// After reset (AUTO_LOAD=1) or on start it streams {addr,data} entries from
// a boot ROM into the table, then arbitrates single host accesses onto the
// same port. Every table write waits for the CPU I/O bus to be idle so a
// window never changes in the middle of an I/O cycle.
// Optional build macro: DECODE_CFG_SHADOW_EN adds a shadow copy of the table
// so host reads return real data; without it host reads return 8'h00.
module decode_cfg_sequencer
    import decode_cfg_sequencer_pkg::*;
#(
    parameter int NUM_WIN   = 4,
    parameter int ROM_AW    = 4,
    parameter bit AUTO_LOAD = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              iorq_n,
    input  logic              start,
    input  logic [ROM_AW:0]   rom_len,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [7:0]        host_addr,
    input  logic [7:0]        host_wdata,
    output logic              host_ack,
    output logic [7:0]        host_rdata,
    output logic              cfg_we,
    output logic [7:0]        cfg_addr,
    output logic [7:0]        cfg_wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int              TBL_SIZE  = table_size(NUM_WIN);
    localparam logic [7:0]      TBL_LIMIT = 8'(TBL_SIZE);
    localparam logic [ROM_AW:0] LEN_ONE   = 1;

    state_t              state_reg, state_next;
    logic [ROM_AW-1:0]   rom_addr_reg, rom_addr_next;
    logic [ROM_AW:0]     len_reg, len_next;
    logic [7:0]          cfg_addr_reg, cfg_addr_next;
    logic [7:0]          cfg_wdata_reg, cfg_wdata_next;
    logic                cfg_we_reg, cfg_we_next;
    logic                host_ack_reg, host_ack_next;
    logic [7:0]          host_rdata_reg, host_rdata_next;
    logic                done_reg, done_next;
    logic                err_reg, err_next;
    logic                auto_pend_reg, auto_pend_next;

    logic                bus_idle;
    logic                entry_done;
    logic                load_last;
    logic [7:0]          rom_cfg_addr;
    logic                rom_in_range;
    logic                host_in_range;
    logic [7:0]          shadow_rd;

    decode_cfg_sequencer_sync2 #(
        .RST_VAL (1'b1)
    ) u_iorq_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (iorq_n),
        .q     (bus_idle)
    );

    assign rom_cfg_addr  = rom_data[15:8];
    assign rom_in_range  = (rom_cfg_addr < TBL_LIMIT);
    assign host_in_range = (host_addr < TBL_LIMIT);
    assign load_last     = ({1'b0, rom_addr_reg} == (len_reg - LEN_ONE));

`ifdef DECODE_CFG_SHADOW_EN
    localparam int IDX_W = (TBL_SIZE > 1) ? $clog2(TBL_SIZE) : 1;

    logic [7:0] shadow_arr [TBL_SIZE];

    genvar gi;
    generate
        for (gi = 0; gi < TBL_SIZE; gi++) begin : g_shadow
            logic [7:0] entry_reg;

            // Mirror every table write that targets this entry.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    entry_reg <= '0;
                end else if (cfg_we_reg && (cfg_addr_reg == 8'(gi))) begin
                    entry_reg <= cfg_wdata_reg;
                end
            end

            assign shadow_arr[gi] = entry_reg;
        end
    endgenerate

    assign shadow_rd = shadow_arr[host_addr[IDX_W-1:0]];
`else
    assign shadow_rd = 8'h00;
`endif

    // State and output registers; reset aborts any load in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            rom_addr_reg   <= '0;
            len_reg        <= '0;
            cfg_addr_reg   <= '0;
            cfg_wdata_reg  <= '0;
            cfg_we_reg     <= 1'b0;
            host_ack_reg   <= 1'b0;
            host_rdata_reg <= '0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
            auto_pend_reg  <= AUTO_LOAD;
        end else begin
            state_reg      <= state_next;
            rom_addr_reg   <= rom_addr_next;
            len_reg        <= len_next;
            cfg_addr_reg   <= cfg_addr_next;
            cfg_wdata_reg  <= cfg_wdata_next;
            cfg_we_reg     <= cfg_we_next;
            host_ack_reg   <= host_ack_next;
            host_rdata_reg <= host_rdata_next;
            done_reg       <= done_next;
            err_reg        <= err_next;
            auto_pend_reg  <= auto_pend_next;
        end
    end

    // Next-state logic: load sequencing, host arbitration and pulse generation.
    always_comb begin
        state_next      = state_reg;
        rom_addr_next   = rom_addr_reg;
        len_next        = len_reg;
        cfg_addr_next   = cfg_addr_reg;
        cfg_wdata_next  = cfg_wdata_reg;
        cfg_we_next     = 1'b0;
        host_ack_next   = 1'b0;
        host_rdata_next = '0;
        done_next       = done_reg;
        err_next        = err_reg;
        auto_pend_next  = auto_pend_reg;
        entry_done      = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                // A load request always wins over a pending host access.
                if (start || auto_pend_reg) begin
                    auto_pend_next = 1'b0;
                    err_next       = 1'b0;
                    len_next       = rom_len;
                    rom_addr_next  = '0;
                    if (rom_len == '0) begin
                        done_next  = 1'b1;
                    end else begin
                        done_next  = 1'b0;
                        state_next = ST_FETCH;
                    end
                end else if (host_req) begin
                    state_next = ST_HOST;
                end
            end

            ST_FETCH: begin
                // rom_addr is stable this cycle; ROM data follows next cycle.
                state_next = ST_LATCH;
            end

            ST_LATCH: begin
                // Hold the entry until the I/O bus is quiet.
                if (bus_idle) begin
                    if (rom_cfg_addr == CFG_END_MARK) begin
                        done_next  = 1'b1;
                        state_next = ST_IDLE;
                    end else if (!rom_in_range) begin
                        err_next   = 1'b1;
                        entry_done = 1'b1;
                    end else begin
                        cfg_addr_next  = rom_cfg_addr;
                        cfg_wdata_next = rom_data[7:0];
                        cfg_we_next    = 1'b1;
                        state_next     = ST_WRITE;
                    end
                end
            end

            ST_WRITE: begin
                entry_done = 1'b1;
            end

            ST_HOST: begin
                if (!host_in_range) begin
                    err_next      = 1'b1;
                    host_ack_next = 1'b1;
                    state_next    = ST_HACK;
                end else if (!host_we) begin
                    host_ack_next   = 1'b1;
                    host_rdata_next = shadow_rd;
                    state_next      = ST_HACK;
                end else if (bus_idle) begin
                    cfg_addr_next  = host_addr;
                    cfg_wdata_next = host_wdata;
                    cfg_we_next    = 1'b1;
                    host_ack_next  = 1'b1;
                    state_next     = ST_HACK;
                end
            end

            ST_HACK: begin
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Shared step to the next ROM entry, for both written and skipped entries.
        if (entry_done) begin
            rom_addr_next = rom_addr_reg + 1'b1;
            if (load_last) begin
                done_next  = 1'b1;
                state_next = ST_IDLE;
            end else begin
                state_next = ST_FETCH;
            end
        end
    end

    assign rom_addr   = rom_addr_reg;
    assign cfg_we     = cfg_we_reg;
    assign cfg_addr   = cfg_addr_reg;
    assign cfg_wdata  = cfg_wdata_reg;
    assign host_ack   = host_ack_reg;
    assign host_rdata = host_rdata_reg;
    assign done       = done_reg;
    assign err        = err_reg;
    assign busy       = (state_reg != ST_IDLE);

endmodule
